// File: rtl/gtfmac_axil_csr_slave.sv
// AXI4-Lite CSR responder for one GTFMAC latency-measurement channel:
// version, scratch, control, live status, clear-on-read event counter, W1C sticky errors.
module gtfmac_axil_csr_slave #(
   parameter int unsigned ADDR_W   = 6,
   parameter logic [31:0] VERSION  = 32'h0001_0000,
   parameter logic [31:0] CTRL_RST = 32'h0000_0000
) (
   input  logic        s_axi_aclk,
   input  logic        s_axi_areset,
   input  logic [31:0] s_axi_awaddr,
   input  logic        s_axi_awvalid,
   output logic        s_axi_awready,
   input  logic [31:0] s_axi_wdata,
   input  logic [3:0]  s_axi_wstrb,
   input  logic        s_axi_wvalid,
   output logic        s_axi_wready,
   output logic [1:0]  s_axi_bresp,
   output logic        s_axi_bvalid,
   input  logic        s_axi_bready,
   input  logic [31:0] s_axi_araddr,
   input  logic        s_axi_arvalid,
   output logic        s_axi_arready,
   output logic [31:0] s_axi_rdata,
   output logic [1:0]  s_axi_rresp,
   output logic        s_axi_rvalid,
   input  logic        s_axi_rready,
   output logic [31:0] ctrl_out,
   input  logic [31:0] status_in,
   input  logic        event_in,
   input  logic [7:0]  err_in
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned ERR_W  = 8;
   localparam int unsigned IDX_W  = ADDR_W - 2;

   localparam logic [IDX_W-1:0] IDX_VERSION = IDX_W'(0);
   localparam logic [IDX_W-1:0] IDX_SCRATCH = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_CTRL    = IDX_W'(2);
   localparam logic [IDX_W-1:0] IDX_STATUS  = IDX_W'(3);
   localparam logic [IDX_W-1:0] IDX_EVCNT   = IDX_W'(4);
   localparam logic [IDX_W-1:0] IDX_STICKY  = IDX_W'(5);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic              aw_held_q, aw_held_d;
   logic              w_held_q,  w_held_d;
   logic [IDX_W-1:0]  awidx_q,   awidx_d;
   logic [DATA_W-1:0] wdata_q,   wdata_d;
   logic [STRB_W-1:0] wstrb_q,   wstrb_d;
   logic              bvalid_q,  bvalid_d;
   logic [1:0]        bresp_q,   bresp_d;
   logic              rvalid_q,  rvalid_d;
   logic [DATA_W-1:0] rdata_q,   rdata_d;
   logic [1:0]        rresp_q,   rresp_d;
   logic [DATA_W-1:0] scratch_q, scratch_d;
   logic [DATA_W-1:0] ctrl_q,    ctrl_d;
   logic [DATA_W-1:0] evcnt_q,   evcnt_d;
   logic [ERR_W-1:0]  sticky_q,  sticky_d;

   logic              aw_hs, w_hs, ar_hs, wr_go, wr_mapped;
   logic [IDX_W-1:0]  wr_idx, rd_idx;
   logic [DATA_W-1:0] wr_data, wr_mask, rd_mux;
   logic [STRB_W-1:0] wr_strb;
   logic [ERR_W-1:0]  sticky_clr;
   logic              rd_slverr;
   logic              unused_c;

   assign s_axi_awready = !s_axi_areset && !aw_held_q && !bvalid_q;
   assign s_axi_wready  = !s_axi_areset && !w_held_q && !bvalid_q;
   assign s_axi_arready = !s_axi_areset && !rvalid_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;
   assign ctrl_out      = ctrl_q;

   assign unused_c = ^{s_axi_awaddr[31:ADDR_W], s_axi_awaddr[1:0],
                       s_axi_araddr[31:ADDR_W], s_axi_araddr[1:0]};

   assign aw_hs = s_axi_awvalid && s_axi_awready;
   assign w_hs  = s_axi_wvalid && s_axi_wready;
   assign ar_hs = s_axi_arvalid && s_axi_arready;

   // Write executes on the edge where both halves are available, held or live.
   assign wr_go     = (aw_held_q || aw_hs) && (w_held_q || w_hs);
   assign wr_idx    = aw_held_q ? awidx_q : s_axi_awaddr[ADDR_W-1:2];
   assign wr_data   = w_held_q ? wdata_q : s_axi_wdata;
   assign wr_strb   = w_held_q ? wstrb_q : s_axi_wstrb;
   assign wr_mapped = (wr_idx <= IDX_STICKY);
   assign rd_idx    = s_axi_araddr[ADDR_W-1:2];

   always_comb begin
      wr_mask = '0;
      for (int b = 0; b < STRB_W; b++) begin
         wr_mask[b*8 +: 8] = {8{wr_strb[b]}};
      end
   end

   always_comb begin
      rd_mux    = '0;
      rd_slverr = 1'b0;
      case (rd_idx)
         IDX_VERSION: rd_mux = VERSION;
         IDX_SCRATCH: rd_mux = scratch_q;
         IDX_CTRL:    rd_mux = ctrl_q;
         IDX_STATUS:  rd_mux = status_in;
         IDX_EVCNT:   rd_mux = evcnt_q;
         IDX_STICKY:  rd_mux = DATA_W'(sticky_q);
         default:     rd_slverr = 1'b1;
      endcase
   end

   always_comb begin
      aw_held_d  = aw_held_q;
      w_held_d   = w_held_q;
      awidx_d    = awidx_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      rvalid_d   = rvalid_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      scratch_d  = scratch_q;
      ctrl_d     = ctrl_q;
      evcnt_d    = evcnt_q;
      sticky_clr = '0;

      if (aw_hs) begin
         aw_held_d = 1'b1;
         awidx_d   = s_axi_awaddr[ADDR_W-1:2];
      end
      if (w_hs) begin
         w_held_d = 1'b1;
         wdata_d  = s_axi_wdata;
         wstrb_d  = s_axi_wstrb;
      end

      if (bvalid_q && s_axi_bready) begin
         bvalid_d = 1'b0;
      end
      if (wr_go) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = wr_mapped ? RESP_OKAY : RESP_SLVERR;
         if (wr_idx == IDX_SCRATCH) scratch_d = (scratch_q & ~wr_mask) | (wr_data & wr_mask);
         if (wr_idx == IDX_CTRL)    ctrl_d    = (ctrl_q & ~wr_mask) | (wr_data & wr_mask);
         if (wr_idx == IDX_STICKY && wr_strb[0]) sticky_clr = wr_data[ERR_W-1:0];
      end

      // Read samples pre-write register values; R holds until rready.
      if (rvalid_q && s_axi_rready) begin
         rvalid_d = 1'b0;
      end
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_mux;
         rresp_d  = rd_slverr ? RESP_SLVERR : RESP_OKAY;
      end

      // Clear-on-read restarts from the coincident event, otherwise saturating count.
      if (ar_hs && rd_idx == IDX_EVCNT) begin
         evcnt_d = DATA_W'(event_in);
      end else if (event_in && evcnt_q != '1) begin
         evcnt_d = evcnt_q + DATA_W'(1);
      end
   end

   assign sticky_d = (sticky_q & ~sticky_clr) | err_in;

   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         awidx_q   <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
         scratch_q <= '0;
         ctrl_q    <= CTRL_RST;
         evcnt_q   <= '0;
         sticky_q  <= '0;
      end else begin
         aw_held_q <= aw_held_d;
         w_held_q  <= w_held_d;
         awidx_q   <= awidx_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         scratch_q <= scratch_d;
         ctrl_q    <= ctrl_d;
         evcnt_q   <= evcnt_d;
         sticky_q  <= sticky_d;
      end
   end

endmodule

// File: tb/tb_gtfmac_axil_csr_slave.sv
// Scoreboard bench for gtfmac_axil_csr_slave: expected B/R responses queued at issue, checked on arrival.
module tb_gtfmac_axil_csr_slave;

   localparam logic [31:0] VERSION  = 32'h0001_0000;
   localparam logic [31:0] CTRL_RST = 32'h0000_00C3;
   localparam int          TMO      = 20;

   logic        clk = 1'b0;
   logic        areset;
   logic [31:0] awaddr, wdata, araddr, rdata, ctrl_out, status_in;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready, event_in;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic [7:0]  err_in;

   int nvec = 0;
   int nfail = 0;
   logic [33:0] rd_exp_q[$];
   logic [1:0]  b_exp_q[$];

   always #5 clk = ~clk;

   gtfmac_axil_csr_slave #(.ADDR_W(6), .VERSION(VERSION), .CTRL_RST(CTRL_RST)) dut (
      .s_axi_aclk(clk), .s_axi_areset(areset),
      .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
      .ctrl_out(ctrl_out), .status_in(status_in), .event_in(event_in), .err_in(err_in)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pop_b(input string tag);
      logic [1:0] e;
      if (b_exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = b_exp_q.pop_front();
         chk(tag, 32'(bresp), 32'(e));
      end
   endtask

   task automatic pop_r(input string tag);
      logic [33:0] e;
      if (rd_exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = rd_exp_q.pop_front();
         chk({tag, "_data"}, rdata, e[31:0]);
         chk({tag, "_resp"}, 32'(rresp), 32'(e[33:32]));
      end
   endtask

   // W is offered w_lead cycles ahead of AW (0 = together); bready withheld b_hold cycles.
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int w_lead, input int b_hold, input logic [1:0] exp_resp);
      int n;
      b_exp_q.push_back(exp_resp);
      awaddr = addr; wdata = data; wstrb = strb; wvalid = 1'b1;
      if (w_lead == 0) awvalid = 1'b1;
      n = 0;
      while (!wready && n < TMO) begin tick(); n++; end
      if (n >= TMO) chk("w_timeout", 32'd0, 32'd1);
      tick();
      wvalid = 1'b0;
      if (w_lead > 0) begin
         chk("wready_after_w", 32'(wready), 32'd0);
         repeat (w_lead - 1) tick();
         chk("bvalid_before_aw", 32'(bvalid), 32'd0);
         awvalid = 1'b1;
         n = 0;
         while (!awready && n < TMO) begin tick(); n++; end
         if (n >= TMO) chk("aw_timeout", 32'd0, 32'd1);
         tick();
      end
      awvalid = 1'b0;
      chk("bvalid_latency", 32'(bvalid), 32'd1);
      for (int i = 0; i < b_hold; i++) begin
         tick();
         chk("bvalid_hold", 32'(bvalid), 32'd1);
         chk("awready_blocked", 32'(awready), 32'd0);
      end
      bready = 1'b1;
      pop_b($sformatf("bresp@%0h", addr));
      tick();
      bready = 1'b0;
      chk("bvalid_clear", 32'(bvalid), 32'd0);
   endtask

   task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input logic ev);
      int n;
      rd_exp_q.push_back({exp_resp, exp_data});
      araddr = addr; arvalid = 1'b1;
      n = 0;
      while (!arready && n < TMO) begin tick(); n++; end
      if (n >= TMO) chk("ar_timeout", 32'd0, 32'd1);
      event_in = ev;
      tick();
      arvalid = 1'b0; event_in = 1'b0;
      chk("rvalid_latency", 32'(rvalid), 32'd1);
      pop_r($sformatf("rd@%0h", addr));
      rready = 1'b1;
      tick();
      rready = 1'b0;
      chk("rvalid_clear", 32'(rvalid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      areset = 1'b1;
      awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arvalid = 1'b0; rready = 1'b0;
      status_in = 32'hDEAD_BEEF; event_in = 1'b0; err_in = '0;
      repeat (3) tick();
      chk("rst_bvalid", 32'(bvalid), 32'd0);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_ctrl", ctrl_out, CTRL_RST);
      chk("rst_readies", 32'({awready, wready, arready}), 32'd0);
      areset = 1'b0;
      tick();

      axi_read(32'h00, VERSION, 2'b00, 1'b0);
      axi_read(32'h08, CTRL_RST, 2'b00, 1'b0);
      axi_read(32'h04, 32'h0, 2'b00, 1'b0);

      // Byte-strobed scratch write with W leading AW and a stalled B.
      axi_write(32'h04, 32'hFFFF_FFFF, 4'hF, 0, 0, 2'b00);
      axi_write(32'h04, 32'hA5A5_A5A5, 4'b0101, 3, 4, 2'b00);
      axi_read(32'h04, 32'hFFA5_FFA5, 2'b00, 1'b0);

      axi_write(32'h08, 32'h1234_5678, 4'b0011, 1, 0, 2'b00);
      chk("ctrl_out_strb", ctrl_out, 32'h0000_5678);
      axi_read(32'h08, 32'h0000_5678, 2'b00, 1'b0);
      axi_read(32'h0C, 32'hDEAD_BEEF, 2'b00, 1'b0);

      for (int i = 0; i < 5; i++) begin
         event_in = 1'b1; tick();
         event_in = 1'b0; tick();
      end
      axi_read(32'h10, 32'd5, 2'b00, 1'b0);
      axi_read(32'h10, 32'd0, 2'b00, 1'b1);
      axi_read(32'h10, 32'd1, 2'b00, 1'b0);

      err_in = 8'h03; tick();
      err_in = 8'h01;
      axi_write(32'h14, 32'h0000_0001, 4'hF, 0, 0, 2'b00);
      err_in = 8'h00;
      axi_read(32'h14, 32'h0000_0003, 2'b00, 1'b0);
      axi_write(32'h14, 32'h0000_0003, 4'hF, 0, 0, 2'b00);
      axi_read(32'h14, 32'h0000_0000, 2'b00, 1'b0);

      axi_write(32'h20, 32'h0BAD_0BAD, 4'hF, 0, 0, 2'b10);
      axi_read(32'h3C, 32'h0, 2'b10, 1'b0);
      axi_write(32'h0C, 32'h1111_1111, 4'hF, 0, 0, 2'b00);
      axi_write(32'h00, 32'h2222_2222, 4'hF, 2, 0, 2'b00);
      axi_read(32'h00, VERSION, 2'b00, 1'b0);
      axi_read(32'h04, 32'hFFA5_FFA5, 2'b00, 1'b0);
      axi_read(32'h08, 32'h0000_5678, 2'b00, 1'b0);

      // Same-edge read and write of SCRATCH: read sees the old value.
      b_exp_q.push_back(2'b00);
      rd_exp_q.push_back({2'b00, 32'hFFA5_FFA5});
      araddr = 32'h04; arvalid = 1'b1;
      awaddr = 32'h04; awvalid = 1'b1; wdata = 32'h1357_9BDF; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      chk("coinc_bvalid", 32'(bvalid), 32'd1);
      chk("coinc_rvalid", 32'(rvalid), 32'd1);
      pop_b("coinc_bresp");
      pop_r("coinc_rd");
      bready = 1'b1; rready = 1'b1;
      tick();
      bready = 1'b0; rready = 1'b0;
      axi_read(32'h04, 32'h1357_9BDF, 2'b00, 1'b0);

      // Reset with AW held and R pending.
      axi_write(32'h08, 32'hFFFF_0000, 4'hF, 0, 0, 2'b00);
      awaddr = 32'h08; awvalid = 1'b1; araddr = 32'h00; arvalid = 1'b1;
      tick();
      awvalid = 1'b0; arvalid = 1'b0;
      chk("pre_rst_awready", 32'(awready), 32'd0);
      chk("pre_rst_rvalid", 32'(rvalid), 32'd1);
      chk("pre_rst_ctrl", ctrl_out, 32'hFFFF_0000);
      areset = 1'b1;
      tick();
      chk("mid_rst_bvalid", 32'(bvalid), 32'd0);
      chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
      chk("mid_rst_ctrl", ctrl_out, CTRL_RST);
      chk("mid_rst_readies", 32'({awready, wready, arready}), 32'd0);
      tick();
      chk("mid_rst_readies2", 32'({awready, wready, arready}), 32'd0);
      areset = 1'b0;
      tick();
      chk("post_rst_readies", 32'({awready, wready, arready}), 32'd7);
      chk("post_rst_bvalid", 32'(bvalid), 32'd0);
      axi_read(32'h04, 32'h0, 2'b00, 1'b0);
      axi_write(32'h08, 32'h0000_0055, 4'hF, 0, 0, 2'b00);
      axi_read(32'h08, 32'h0000_0055, 2'b00, 1'b0);

      chk("sb_drained", 32'(b_exp_q.size() + rd_exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/gtfmac_axil_csr_slave.md
Name: gtfmac_axil_csr_slave

Overview:
- AXI4-Lite responder (slave end) for one master port of the GTFMAC AXI crosspoint.
- Holds the control/status register bank for one GTFMAC latency-measurement channel: version, scratch, control outputs, status inputs, a clear-on-read event counter and W1C sticky error bits.
- Instantiated once per crossbar master port (M0, M1).
- Decodes only the low address bits; the crossbar has already routed the transaction.

Parameters:
- ADDR_W, 6, number of low awaddr/araddr bits decoded (word-aligned, bits [1:0] ignored)
- VERSION, 32'h0001_0000, value returned by the VERSION register
- CTRL_RST, 32'h0000_0000, reset value of CTRL

Ports:
- s_axi_aclk  in  1  single clock
- s_axi_areset  in  1  synchronous, active-high reset
- s_axi_awaddr  in  32  write address
- s_axi_awvalid  in  1  AW valid
- s_axi_awready  out  1  AW ready
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte strobes
- s_axi_wvalid  in  1  W valid
- s_axi_wready  out  1  W ready
- s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1  B valid
- s_axi_bready  in  1  B ready
- s_axi_araddr  in  32  read address
- s_axi_arvalid  in  1  AR valid
- s_axi_arready  out  1  AR ready
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid  out  1  R valid
- s_axi_rready  in  1  R ready
- ctrl_out  out  32  CTRL register contents
- status_in  in  32  live status, sampled at read
- event_in  in  1  one-cycle event pulse for EVENT_CNT
- err_in  in  8  per-bit error pulses into STICKY

Behaviour:
- Reset (s_axi_areset=1 at a clock edge):
  - bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
  - ctrl_out=CTRL_RST; SCRATCH=0, EVENT_CNT=0, STICKY=0.
  - AW/W hold flags cleared.
  - awready, wready and arready are forced 0 while reset is high.
  - Reset mid-transaction drops pending AW/W/B/R with no response.
- Register map (offset = addr[ADDR_W-1:2]<<2):
  - 0x00 VERSION: RO.
  - 0x04 SCRATCH: RW.
  - 0x08 CTRL: RW.
  - 0x0C STATUS: RO, returns status_in.
  - 0x10 EVENT_CNT: RO, clear-on-read, 32-bit, saturates at 0xFFFFFFFF.
  - 0x14 STICKY: bits [7:0] W1C, bits [31:8] read 0.
- Write channel:
  - awready = !aw_held & !bvalid; wready = !w_held & !bvalid.
  - AW and W are accepted independently in any order and latched.
  - In the cycle both are available (held or handshaking now), the write executes at that edge and bvalid=1 from the next cycle.
  - Latency is 1 cycle from the later of the AW/W handshakes to bvalid.
  - bvalid holds until bready; awready/wready stay low while bvalid=1.
  - RW registers honour wstrb per byte.
  - Writes to RO offsets: ignored, bresp=OKAY.
  - Unmapped offsets (0x18 and above): ignored, bresp=SLVERR (2'b10).
- Read channel:
  - arready = !rvalid.
  - AR handshake in cycle T gives rvalid=1 and rdata/rresp in T+1; these hold stable until rready.
  - Sustained throughput is 1 read per 2 cycles.
  - Unmapped reads: rdata=0, rresp=SLVERR.
- Read and write are fully independent. If both hit the same register in the same cycle, the read returns the pre-write value.
- EVENT_CNT:
  - +1 per cycle with event_in=1.
  - Clearing happens at the AR-handshake edge.
  - Read coincident with event_in: read returns the old value and the counter becomes 1.
  - Saturated counter does not wrap.
- STICKY: each bit is next = (cur & ~(wr_hit & wstrb[0] & wdata[i])) | err_in[i]. Set wins over clear in the same cycle.

Test Plan:
- Reset, then read 0x00 -> rvalid 1 cycle after AR; rdata=32'h0001_0000, rresp=0. Read 0x08 -> CTRL_RST.
- W presented 3 cycles before AW (0x04, data 0xA5A5A5A5, wstrb 4'b0101), prior SCRATCH=0xFFFFFFFF:
  - wready low after the W handshake.
  - bvalid 1 cycle after AW; bready held low 4 cycles keeps bvalid and blocks a new AW.
  - Readback = 0xFFA5FFA5.
- Pulse event_in 5 times, then read 0x10 -> 5. Read again with event_in=1 on the AR-handshake cycle -> 0. Next read -> 1.
- err_in=8'h03 pulse, then write 0x14 data 0x01 while err_in[0] pulses again:
  - Read -> 0x03 (set wins).
  - Write 0x03 with no pulses -> read 0x00.
- Write 0x20 -> bresp=2'b10, no register changes. Read 0x3C -> rdata=0, rresp=2'b10. Write 0x0C -> bresp=OKAY.
- Assert s_axi_areset with AW held and rvalid pending:
  - Next cycle bvalid=rvalid=0, ctrl_out=CTRL_RST.
  - Readies 0 during reset and re-assert the cycle after reset deasserts.
